axil_reg_slave: RTL and testbench

- AXI4-Lite responder: a bank of NUM_REGS word registers that a master port of the bus interconnect targets.
- It is the other end of the bus master ports. It accepts AW/W/AR, commits strobed writes, returns B/R responses and exports the register contents to fabric logic.
- Single outstanding transaction per direction. The read and write paths are independent.

---
 rtl/axil_reg_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite responder exposing NUM_REGS word registers.
// Write path (AW/W/B) and read path (AR/R) are independent, each with a single
// outstanding transaction. Register contents are exported flat on reg_out.
// Optional feature: define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range
// accesses with SLVERR instead of OKAY (the access is dropped either way).
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 2,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           s0_axi_aclk,
    input  logic                           s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
    input  logic                           s0_axi_awvalid,
    output logic                           s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
    input  logic                           s0_axi_wvalid,
    output logic                           s0_axi_wready,
    output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
    output logic                           s0_axi_bvalid,
    input  logic                           s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
    input  logic                           s0_axi_arvalid,
    output logic                           s0_axi_arready,
    output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
    output logic                           s0_axi_rvalid,
    input  logic                           s0_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Decode arithmetic is one bit wider than the address so that an address
    // below BASE_ADDR shows up as a set top bit instead of wrapping around.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] NUM_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY = '0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [RESP_WIDTH-1:0] RESP_OOR  = RESP_WIDTH'(2);
`else
    localparam logic [RESP_WIDTH-1:0] RESP_OOR  = '0;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    w_state_t                w_state;
    r_state_t                r_state;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit_en;
    logic                    commit_hit;
    logic [ADDR_WIDTH-1:0]   commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [STRB_WIDTH-1:0]   commit_strb;

    // Byte address -> "register exists here"; addr[1:0] drop out in the shift.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, addr} - BASE_EXT;
        return !off[ADDR_WIDTH] && ((off >> 2) < NUM_LIMIT);
    endfunction

    // Byte address -> register index; only meaningful when addr_in_range().
    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, addr} - BASE_EXT;
        return IDX_WIDTH'(off >> 2);
    endfunction

    assign aw_hs = s0_axi_awvalid && s0_axi_awready;
    assign w_hs  = s0_axi_wvalid  && s0_axi_wready;
    assign ar_hs = s0_axi_arvalid && s0_axi_arready;

    // Select where the committing address/data/strobe come from in each write state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        commit_en   = 1'b0;
        commit_addr = s0_axi_awaddr;
        commit_data = s0_axi_wdata;
        commit_strb = s0_axi_wstrb;
        case (w_state)
            W_IDLE: begin
                commit_en = aw_hs && w_hs;
            end
            W_HAVE_AW: begin
                commit_en   = w_hs;
                commit_addr = aw_addr_q;
            end
            W_HAVE_W: begin
                commit_en   = aw_hs;
                commit_data = wdata_q;
                commit_strb = wstrb_q;
            end
            default: begin
                commit_en = 1'b0;
            end
        endcase
    end

    assign commit_hit = commit_en && addr_in_range(commit_addr);

    // Write channel FSM: collects AW and W in either order, then holds B until bready.
    always_ff @(posedge s0_axi_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (s0_axi_areset) begin
            w_state        <= W_IDLE;
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            s0_axi_bvalid  <= 1'b0;
            s0_axi_bresp   <= RESP_OKAY;
            aw_addr_q      <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s0_axi_awready <= 1'b1;
                    s0_axi_wready  <= 1'b1;
                    if (aw_hs && w_hs) begin
                        s0_axi_awready <= 1'b0;
                        s0_axi_wready  <= 1'b0;
                        s0_axi_bvalid  <= 1'b1;
                        s0_axi_bresp   <= commit_hit ? RESP_OKAY : RESP_OOR;
                        w_state        <= W_RESP;
                    end else if (aw_hs) begin
                        aw_addr_q      <= s0_axi_awaddr;
                        s0_axi_awready <= 1'b0;
                        w_state        <= W_HAVE_AW;
                    end else if (w_hs) begin
                        wdata_q        <= s0_axi_wdata;
                        wstrb_q        <= s0_axi_wstrb;
                        s0_axi_wready  <= 1'b0;
                        w_state        <= W_HAVE_W;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        s0_axi_wready <= 1'b0;
                        s0_axi_bvalid <= 1'b1;
                        s0_axi_bresp  <= commit_hit ? RESP_OKAY : RESP_OOR;
                        w_state       <= W_RESP;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        s0_axi_awready <= 1'b0;
                        s0_axi_bvalid  <= 1'b1;
                        s0_axi_bresp   <= commit_hit ? RESP_OKAY : RESP_OOR;
                        w_state        <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s0_axi_bready) begin
                        s0_axi_bvalid  <= 1'b0;
                        s0_axi_awready <= 1'b1;
                        s0_axi_wready  <= 1'b1;
                        w_state        <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Register bank: byte-strobed update on commit to an in-range address.
    always_ff @(posedge s0_axi_aclk) begin
        // NOTE: the bank is a handful of flops with a defined reset value, so it is cleared; a real RAM would not be.
        if (s0_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_hit) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (commit_strb[b]) begin
                    regs[addr_index(commit_addr)][8*b +: 8] <= commit_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel FSM: capture the addressed register on AR, hold R until rready.
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            r_state        <= R_IDLE;
            s0_axi_arready <= 1'b0;
            s0_axi_rvalid  <= 1'b0;
            s0_axi_rresp   <= RESP_OKAY;
            s0_axi_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s0_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        // A write committing at this same edge is not yet visible here.
                        if (addr_in_range(s0_axi_araddr)) begin
                            s0_axi_rdata <= regs[addr_index(s0_axi_araddr)];
                            s0_axi_rresp <= RESP_OKAY;
                        end else begin
                            s0_axi_rdata <= '0;
                            s0_axi_rresp <= RESP_OOR;
                        end
                        s0_axi_arready <= 1'b0;
                        s0_axi_rvalid  <= 1'b1;
                        r_state        <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s0_axi_rready) begin
                        s0_axi_rvalid  <= 1'b0;
                        s0_axi_arready <= 1'b1;
                        r_state        <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Flat export of the register bank.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed cases followed by random
// reads/writes compared against a word-array model of the register bank.
module tb_axil_reg_slave;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam int BASE = 0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic              s0_axi_aclk = 1'b0;
    logic              s0_axi_areset = 1'b1;
    logic [AW-1:0]     s0_axi_awaddr = '0;
    logic              s0_axi_awvalid = 1'b0;
    logic              s0_axi_awready;
    logic [DW-1:0]     s0_axi_wdata = '0;
    logic [DW/8-1:0]   s0_axi_wstrb = '0;
    logic              s0_axi_wvalid = 1'b0;
    logic              s0_axi_wready;
    logic [1:0]        s0_axi_bresp;
    logic              s0_axi_bvalid;
    logic              s0_axi_bready = 1'b0;
    logic [AW-1:0]     s0_axi_araddr = '0;
    logic              s0_axi_arvalid = 1'b0;
    logic              s0_axi_arready;
    logic [DW-1:0]     s0_axi_rdata;
    logic [1:0]        s0_axi_rresp;
    logic              s0_axi_rvalid;
    logic              s0_axi_rready = 1'b0;
    logic [NR*DW-1:0]  reg_out;

    axil_reg_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(2), .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .s0_axi_aclk   (s0_axi_aclk),
        .s0_axi_areset (s0_axi_areset),
        .s0_axi_awaddr (s0_axi_awaddr),
        .s0_axi_awvalid(s0_axi_awvalid),
        .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata  (s0_axi_wdata),
        .s0_axi_wstrb  (s0_axi_wstrb),
        .s0_axi_wvalid (s0_axi_wvalid),
        .s0_axi_wready (s0_axi_wready),
        .s0_axi_bresp  (s0_axi_bresp),
        .s0_axi_bvalid (s0_axi_bvalid),
        .s0_axi_bready (s0_axi_bready),
        .s0_axi_araddr (s0_axi_araddr),
        .s0_axi_arvalid(s0_axi_arvalid),
        .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata  (s0_axi_rdata),
        .s0_axi_rresp  (s0_axi_rresp),
        .s0_axi_rvalid (s0_axi_rvalid),
        .s0_axi_rready (s0_axi_rready),
        .reg_out       (reg_out)
    );

    always #5 s0_axi_aclk = ~s0_axi_aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain word array indexed by byte offset / 4.
    logic [DW-1:0] model [NR];

    task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [AW-1:0] addr);
        int off;
        off = int'(addr) - BASE;
        return (off >= 0) && (off / 4 < NR);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        if (!model_in_range(addr)) return '0;
        return model[(int'(addr) - BASE) / 4];
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        int idx;
        if (!model_in_range(addr)) return;
        idx = (int'(addr) - BASE) / 4;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge s0_axi_aclk);
        #1;
    endtask

    task automatic check_ready_idle(input string tag);
        check({tag, "_awready"}, s0_axi_awready, 1);
        check({tag, "_wready"},  s0_axi_wready,  1);
        check({tag, "_arready"}, s0_axi_arready, 1);
    endtask

    // Write with independent AW/W start delays and a bready hold-off after bvalid.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int bhold);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        logic [1:0] exp_resp;
        exp_resp = model_in_range(addr) ? 2'b00 : OOR_RESP;
        while (!(aw_done && w_done)) begin
            if (cyc > 50) begin
                check("wr_timeout", 0, 1);
                s0_axi_awvalid = 0; s0_axi_wvalid = 0;
                return;
            end
            s0_axi_awaddr  = addr;
            s0_axi_awvalid = !aw_done && (cyc >= aw_delay);
            s0_axi_wdata   = data;
            s0_axi_wstrb   = strb;
            s0_axi_wvalid  = !w_done && (cyc >= w_delay);
            if (w_done && !aw_done) check("wready_wait", s0_axi_wready, 0);
            if (aw_done && !w_done) check("awready_wait", s0_axi_awready, 0);
            check("bvalid_early", s0_axi_bvalid, 0);
            hs_aw = s0_axi_awvalid && s0_axi_awready;
            hs_w  = s0_axi_wvalid && s0_axi_wready;
            tick();
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        s0_axi_awvalid = 0;
        s0_axi_wvalid  = 0;
        model_write(addr, data, strb);
        check("bvalid_lat", s0_axi_bvalid, 1);
        check("bresp", s0_axi_bresp, exp_resp);
        check("reg_out", reg_out, model_flat());
        for (int i = 0; i < bhold; i++) begin
            tick();
            check("bvalid_hold", s0_axi_bvalid, 1);
            check("bresp_hold", s0_axi_bresp, exp_resp);
        end
        s0_axi_bready = 1;
        tick();
        s0_axi_bready = 0;
        check("bvalid_drop", s0_axi_bvalid, 0);
    endtask

    // Read with an rready hold-off; returns the observed data.
    task automatic axi_read(input logic [AW-1:0] addr, input int rhold, output logic [DW-1:0] got);
        bit hs;
        int cyc = 0;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        exp_data = model_read(addr);
        exp_resp = model_in_range(addr) ? 2'b00 : OOR_RESP;
        got = '0;
        s0_axi_araddr  = addr;
        s0_axi_arvalid = 1;
        do begin
            if (cyc > 50) begin
                check("rd_timeout", 0, 1);
                s0_axi_arvalid = 0;
                return;
            end
            hs = s0_axi_arready;
            tick();
            cyc++;
        end while (!hs);
        s0_axi_arvalid = 0;
        got = s0_axi_rdata;
        check("rvalid_lat", s0_axi_rvalid, 1);
        check("rdata", s0_axi_rdata, exp_data);
        check("rresp", s0_axi_rresp, exp_resp);
        for (int i = 0; i < rhold; i++) begin
            tick();
            check("rvalid_hold", s0_axi_rvalid, 1);
            check("rdata_hold", s0_axi_rdata, exp_data);
        end
        s0_axi_rready = 1;
        tick();
        s0_axi_rready = 0;
        check("rvalid_drop", s0_axi_rvalid, 0);
    endtask

    task automatic do_reset();
        s0_axi_areset = 1;
        s0_axi_awvalid = 0; s0_axi_wvalid = 0; s0_axi_arvalid = 0;
        s0_axi_bready = 0; s0_axi_rready = 0;
        tick();
        tick();
        check("rst_awready", s0_axi_awready, 0);
        check("rst_wready",  s0_axi_wready,  0);
        check("rst_arready", s0_axi_arready, 0);
        check("rst_bvalid",  s0_axi_bvalid,  0);
        check("rst_rvalid",  s0_axi_rvalid,  0);
        check("rst_rdata",   s0_axi_rdata,   0);
        check("rst_reg_out", reg_out,        0);
        model_clear();
        s0_axi_areset = 0;
        tick();
        check_ready_idle("post_rst");
    endtask

    initial begin
        logic [DW-1:0] rd;

        #1;
        do_reset();

        // Read after reset
        axi_read(8'h04, 0, rd);

        // Full-word write, AW and W together, bready ready immediately
        axi_write(8'h00, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("reg0_export", reg_out[31:0], 32'hDEADBEEF);
        axi_read(8'h00, 0, rd);

        // Strobed write over a preloaded value
        axi_write(8'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
        axi_write(8'h08, 32'h11223344, 4'h5, 0, 0, 0);
        axi_read(8'h08, 1, rd);
        check("strb_merge", rd, 32'hAA22AA44);

        // W three cycles ahead of AW, bready held off 4 cycles
        axi_write(8'h0C, 32'h00000055, 4'hF, 3, 0, 4);
        axi_read(8'h0C, 0, rd);
        check("late_aw", rd, 32'h00000055);

        // AW ahead of W, unaligned address, wstrb = 0 no-op
        axi_write(8'h05, 32'h12345678, 4'hF, 0, 2, 1);
        axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        axi_read(8'h07, 2, rd);

        // Out-of-range accesses
        axi_read(8'h40, 0, rd);
        axi_write(8'h40, 32'hCAFEF00D, 4'hF, 0, 0, 2);
        axi_write(8'hFC, 32'h0BADBEEF, 4'hF, 1, 0, 0);

        // Write commit and read acceptance at the same edge on the same register
        axi_write(8'h04, 32'h00000010, 4'hF, 0, 0, 0);
        s0_axi_awaddr = 8'h04; s0_axi_wdata = 32'h77; s0_axi_wstrb = 4'hF;
        s0_axi_araddr = 8'h04;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_arvalid = 1;
        tick();
        s0_axi_awvalid = 0; s0_axi_wvalid = 0; s0_axi_arvalid = 0;
        check("conc_bvalid", s0_axi_bvalid, 1);
        check("conc_rvalid", s0_axi_rvalid, 1);
        check("conc_rdata_old", s0_axi_rdata, 32'h10);
        model_write(8'h04, 32'h77, 4'hF);
        s0_axi_bready = 1; s0_axi_rready = 1;
        tick();
        s0_axi_bready = 0; s0_axi_rready = 0;
        check("conc_bdrop", s0_axi_bvalid, 0);
        check("conc_rdrop", s0_axi_rvalid, 0);
        axi_read(8'h04, 0, rd);
        check("conc_new", rd, 32'h77);

        // Reset while B is pending
        s0_axi_awaddr = 8'h00; s0_axi_wdata = 32'h99; s0_axi_wstrb = 4'hF;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1;
        tick();
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        check("wresp_pending", s0_axi_bvalid, 1);
        s0_axi_areset = 1;
        tick();
        check("rst_mid_bvalid", s0_axi_bvalid, 0);
        check("rst_mid_regs", reg_out, 0);
        model_clear();
        s0_axi_areset = 0;
        tick();
        check_ready_idle("rst_mid");

        // Reset while only AW has been accepted: nothing may commit afterwards
        s0_axi_awaddr = 8'h08; s0_axi_awvalid = 1;
        tick();
        s0_axi_awvalid = 0;
        s0_axi_areset = 1;
        tick();
        s0_axi_areset = 0;
        tick();
        check_ready_idle("rst_aw");
        check("rst_aw_bvalid", s0_axi_bvalid, 0);
        check("rst_aw_regs", reg_out, 0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2), rd);
        end
        check("final_regs", reg_out, model_flat());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
